spram128x32_req_ctrl: RTL

- Initiator-side controller for a 128x32 single-port SRAM macro wrapper. The macro has these pins: CE, WE, 7-bit A, 32-bit D, 32-bit Q.
- Converts a valid/ready request channel into RAM pin activity. Captures read data one cycle after the access and returns it on a buffered valid/ready response channel.
- After reset, runs a sequencer that zero-clears the whole array before accepting traffic.
- Sits between compute/DMA clients and each scratchpad SRAM instance.

---
 rtl/spram128x32_req_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/spram128x32_req_ctrl.sv
// spram128x32_req_ctrl: request/response controller for a 128x32 single-port SRAM.
// After reset it zero-fills the array, then turns a valid/ready request stream
// into RAM pin activity. Read data is captured the cycle after the access and
// returned through a small in-order response FIFO.
// Optional feature macro: SPRAM_WR_ACK_EN (writes also return a zero response).
//
// Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
// a response transfers on a rising clk edge where rsp_valid && rsp_ready. req_ready
// depends only on registered state, and rsp_rdata holds while rsp_valid && !rsp_ready.
module spram128x32_req_ctrl #(
    parameter int AW         = 7,
    parameter int DW         = 32,
    parameter int DEPTH      = 128,
    parameter int RSP_DEPTH  = 3,
    parameter int INIT_CLEAR = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          init_done,
    output logic          mem_ce,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_q,
    output logic [1:0]    dbg_state
);

    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_clr_cnt;
    logic          r_init_done;
    logic [DW-1:0] r_fifo [RSP_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic          r_rd_inflight;
    logic [CW:0]   w_occ;
    logic          w_accept;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    logic [DW-1:0] w_push_data;

    // Occupancy counts responses stored plus the one still coming from the RAM.
    assign w_occ     = {1'b0, r_cnt} + {{CW{1'b0}}, r_rd_inflight};
    assign req_ready = (r_state == ST_RUN) && (w_occ < (CW+1)'(RSP_DEPTH));
    assign w_accept  = req_valid && req_ready;
    assign rsp_valid = (r_cnt != '0);
    assign rsp_rdata = rsp_valid ? r_fifo[r_rptr] : '0;
    assign w_pop     = rsp_valid && rsp_ready;
    assign w_push    = r_rd_inflight;
    assign init_done = r_init_done;
    assign dbg_state = r_state;

`ifdef SPRAM_WR_ACK_EN
    logic r_inflight_wr;
    assign w_issue     = w_accept;
    assign w_push_data = r_inflight_wr ? '0 : mem_q;

    // Remember whether the in-flight slot belongs to a write acknowledgement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_inflight_wr <= 1'b0;
        else     r_inflight_wr <= w_accept && req_we;
    end
`else
    assign w_issue     = w_accept && !req_we;
    assign w_push_data = mem_q;
`endif

    // State register plus the clear counter and the sticky init_done flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_BOOT;
            r_clr_cnt   <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) r_clr_cnt <= r_clr_cnt + 1'b1;
            if (w_state_nxt == ST_RUN) r_init_done <= 1'b1;
        end
    end

    // Next state and RAM pin drive; pins idle at zero whenever CE is low.
    always_comb begin
        w_state_nxt = r_state;
        mem_ce      = 1'b0;
        mem_we      = 1'b0;
        mem_a       = '0;
        mem_d       = '0;
        case (r_state)
            ST_BOOT: w_state_nxt = (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
            ST_INIT: begin
                mem_ce = 1'b1;
                mem_we = 1'b1;
                mem_a  = r_clr_cnt;
                if (r_clr_cnt == AW'(DEPTH - 1)) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_accept) begin
                    mem_ce = 1'b1;
                    mem_we = req_we;
                    mem_a  = req_addr;
                    mem_d  = req_wdata;
                end
            end
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    // One-cycle marker for an access whose response lands next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rd_inflight <= 1'b0;
        else     r_rd_inflight <= w_issue;
    end

    // Response FIFO: circular buffer, push from the RAM stage, pop on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) r_fifo[i] <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= w_push_data;
                r_wptr <= (r_wptr == PW'(RSP_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PW'(RSP_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            end
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
        end
    end

    // Occupancy gating must make a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && !w_pop && (r_cnt == CW'(RSP_DEPTH))));

endmodule
